// File: rtl/frame_seq_pkg.sv
// ============================================================================
// frame_seq_pkg -- shared state encoding and mode constants for frame_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package frame_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_SINGLE     = 2'd2,
    ST_BURST      = 2'd3
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_BURST  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/frame_seq_wdog.sv
// ============================================================================
// frame_seq_wdog -- cycle watchdog; expired_o flags the cycle the count hits lim_i
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_seq_wdog
  import frame_seq_pkg::*;
#(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [TO_W-1:0] lim_i,
  output logic            expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W:0]   cnt_inc;

  // One extra bit so a lim_i of all-ones is still reachable without wrap.
  assign cnt_inc   = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};
  assign expired_o = enable_i && !clear_i && (lim_i != '0) &&
                     (cnt_inc == {1'b0, lim_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_inc[TO_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_seq_ctrl.sv
// ============================================================================
// frame_seq_ctrl -- single/burst frame sequencer with abort and optional
// watchdog (enabled by defining FRAME_SEQ_TIMEOUT_EN).  Rev 1.0
// ============================================================================
`default_nettype none

module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int BURST_W = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               frame_end,
  input  logic               abort,
  input  logic [TO_W-1:0]    timeout_lim,
  output logic               busy,
  output logic               progress,
  output logic               done,
  output logic [BURST_W-1:0] frames_done,
  output logic               timeout_err
);

  state_e             state_q, state_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] fd_q, fd_d;
  logic               prog_q, prog_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               in_seq;
  logic               wd_expired;
  logic [BURST_W-1:0] fd_inc;
  logic [BURST_W-1:0] eff_len;

  assign in_seq  = (state_q == ST_SINGLE) || (state_q == ST_BURST);
  assign fd_inc  = (fd_q == '1) ? fd_q : fd_q + {{(BURST_W-1){1'b0}}, 1'b1};
  assign eff_len = (len_q == '0) ? {{(BURST_W-1){1'b0}}, 1'b1} : len_q;

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic terr_q, terr_d;
  logic wd_clear;

  assign wd_clear = ((state_q == ST_WAIT_START) && frame_start) ||
                    (in_seq && frame_end);

  frame_seq_wdog #(
    .TO_W (TO_W)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (in_seq),
    .lim_i     (timeout_lim),
    .expired_o (wd_expired)
  );

  assign timeout_err = terr_q;
`else
  logic unused_timeout_lim;

  assign unused_timeout_lim = ^timeout_lim;
  assign wd_expired         = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // Priority inside a sequence: abort, then frame_end, then watchdog.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    fd_d    = fd_q;
    prog_d  = prog_q;
    done_d  = 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
    terr_d  = terr_q;
`endif
    unique case (state_q)
      ST_IDLE: state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (frame_start) begin
          state_d = (mode == MODE_BURST) ? ST_BURST : ST_SINGLE;
          len_d   = burst_len;
          fd_d    = '0;
          prog_d  = 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      ST_SINGLE, ST_BURST: begin
        if (abort) begin
          state_d = ST_WAIT_START;
          prog_d  = 1'b0;
        end else if (frame_end) begin
          fd_d = fd_inc;
          if ((state_q == ST_SINGLE) || (fd_inc == eff_len)) begin
            state_d = ST_WAIT_START;
            prog_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else if (wd_expired) begin
          state_d = ST_WAIT_START;
          prog_d  = 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
          terr_d  = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SINGLE) || (state_d == ST_BURST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      fd_q    <= '0;
      prog_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      fd_q    <= fd_d;
      prog_q  <= prog_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef FRAME_SEQ_TIMEOUT_EN
      terr_q  <= terr_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign progress    = prog_q;
  assign done        = done_q;
  assign frames_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_seq_ctrl.sv
// ============================================================================
// tb_frame_seq_ctrl -- directed scenarios plus random traffic for frame_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_seq_ctrl;

  localparam int BW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          mode = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          frame_end = 1'b0;
  logic          abort = 1'b0;
  logic [TW-1:0] timeout_lim = '0;
  logic          busy, progress, done, timeout_err;
  logic [BW-1:0] frames_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: sequence-level view (waiting vs. running a sequence).
  bit m_idle, m_active, m_burst, m_prog, m_done, m_terr;
  int m_len, m_cnt, m_wd;

  frame_seq_ctrl #(.BURST_W(BW), .TO_W(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .mode        (mode),
    .burst_len   (burst_len),
    .frame_end   (frame_end),
    .abort       (abort),
    .timeout_lim (timeout_lim),
    .busy        (busy),
    .progress    (progress),
    .done        (done),
    .frames_done (frames_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_idle = 1; m_active = 0; m_prog = 0; m_done = 0;
      m_terr = 0; m_cnt = 0; m_len = 0; m_wd = 0;
    end else if (m_idle) begin
      m_idle = 0; m_done = 0;
    end else if (!m_active) begin
      m_done = 0;
      if (frame_start) begin
        m_active = 1; m_burst = mode; m_len = (burst_len == 0) ? 1 : int'(burst_len);
        m_cnt = 0; m_prog = 0; m_terr = 0; m_wd = 0;
      end
    end else begin
      m_done = 0;
      if (abort) begin
        m_active = 0; m_prog = 0;
      end else if (frame_end) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_wd  = 0;
        if (!m_burst || m_cnt == m_len) begin
          m_active = 0; m_prog = 1; m_done = 1;
        end
      end else begin
`ifdef FRAME_SEQ_TIMEOUT_EN
        m_wd++;
        if (timeout_lim != 0 && m_wd == int'(timeout_lim)) begin
          m_active = 0; m_terr = 1; m_prog = 0;
        end
`endif
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("busy", busy, m_active);
    chk("progress", progress, m_prog);
    chk("done", done, m_done);
    chk("frames_done", frames_done, m_cnt);
    chk("timeout_err", timeout_err, m_terr);
  endtask

  task automatic start(input logic md, input int len);
    frame_start = 1; mode = md; burst_len = BW'(len);
    cyc();
    frame_start = 0;
  endtask

  task automatic fend();
    frame_end = 1; cyc(); frame_end = 0;
  endtask

  initial begin
    // Reset and release
    reset = 1; cyc(); cyc();
    chk("rst_busy", busy, 0); chk("rst_fd", frames_done, 0);
    reset = 0; cyc(); cyc();

    // Single frame, frame_end five cycles after start
    start(1'b0, 0);
    chk("single_busy", busy, 1);
    repeat (4) cyc();
    fend();
    chk("single_done", done, 1); chk("single_prog", progress, 1);
    chk("single_fd", frames_done, 1); chk("single_busy_lo", busy, 0);
    cyc();
    chk("single_done_pulse", done, 0);

    // Burst of three
    start(1'b1, 3);
    cyc(); fend(); chk("b3_fd1", frames_done, 1); chk("b3_nodone1", done, 0);
    cyc(); fend(); chk("b3_fd2", frames_done, 2); chk("b3_nodone2", done, 0);
    fend();
    chk("b3_fd3", frames_done, 3); chk("b3_done", done, 1); chk("b3_prog", progress, 1);
    cyc(); cyc();
    chk("b3_fd_hold", frames_done, 3);

    // burst_len 0 behaves as 1
    start(1'b1, 0);
    fend();
    chk("b0_done", done, 1); chk("b0_fd", frames_done, 1); chk("b0_busy", busy, 0);
    cyc();

    // Abort wins over frame_end on second frame of a 4-burst
    start(1'b1, 4);
    fend();
    frame_end = 1; abort = 1; cyc(); frame_end = 0; abort = 0;
    chk("ab_fd", frames_done, 1); chk("ab_done", done, 0);
    chk("ab_prog", progress, 0); chk("ab_busy", busy, 0);
    abort = 1; cyc(); abort = 0;
    chk("ab_wait_noeffect", busy, 0);

    // Watchdog with limit 10
    timeout_lim = 16'd10;
    start(1'b0, 0);
    repeat (9) cyc();
    chk("wd_busy9", busy, 1);
    cyc();
`ifdef FRAME_SEQ_TIMEOUT_EN
    chk("wd_terr", timeout_err, 1); chk("wd_busy", busy, 0); chk("wd_prog", progress, 0);
    cyc();
    start(1'b0, 0);
    chk("wd_terr_clr", timeout_err, 0);
`else
    chk("wd_terr_tied", timeout_err, 0); chk("wd_still_busy", busy, 1);
`endif
    abort = 1; cyc(); abort = 0;
    timeout_lim = '0;

    // Reset mid-burst, frame_start held through release
    start(1'b1, 5);
    fend(); cyc(); fend();
    chk("mr_fd2", frames_done, 2);
    reset = 1; frame_start = 1; mode = 1; burst_len = 8'd5; cyc();
    chk("mr_busy", busy, 0); chk("mr_fd", frames_done, 0); chk("mr_prog", progress, 0);
    reset = 0; cyc();
    chk("mr_idle_ignores", busy, 0);
    cyc();
    chk("mr_wait_accepts", busy, 1);
    frame_start = 0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) timeout_lim = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 12));
      reset       = ($urandom_range(0, 99) == 0);
      frame_start = ($urandom_range(0, 3) == 0);
      mode        = 1'($urandom_range(0, 1));
      burst_len   = BW'($urandom_range(0, 5));
      frame_end   = ($urandom_range(0, 2) == 0);
      abort       = ($urandom_range(0, 19) == 0);
      cyc();
    end
    reset = 0; frame_start = 0; frame_end = 0; abort = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
